// File: rtl/seg_pkg.sv
// Shared constants and FSM state type for the seven-segment scan controller.
package seg_pkg;
  localparam int CODE_W     = 5;
  localparam int NUM_DIGITS = 4;
  localparam logic [CODE_W-1:0] CODE_BLANK = 5'd18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Active-low one-hot anode pattern for the selected digit.
  function automatic logic [NUM_DIGITS-1:0] anode_sel_n(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction
endpackage

// File: rtl/seg_slot_timer.sv
// Per-digit slot counter: counts 0..TICK_DIV-1, flags end of guard and end of slot.
module seg_slot_timer #(
  parameter int TICK_DIV     = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_guard_done,
  output logic o_slot_end
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear || (r_count == SLOT_LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_guard_done = (r_count == GUARD_LAST);
  assign o_slot_end   = (r_count == SLOT_LAST);
endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-boundary double buffering.
// Optional digit blinking is enabled by defining SEG_BLINK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int GUARD_CYCLES = 16
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [19:0] code_in,
`ifdef SEG_BLINK_EN
  input  logic [3:0]  blink_mask,
`endif
  output logic [3:0]  anode,
  output logic [4:0]  code_out,
  output logic [1:0]  digit_sel,
  output logic        frame_start,
  output logic        pending
);
  localparam int AW = CODE_W * NUM_DIGITS;

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_active, w_active_nxt;
  logic [AW-1:0]     r_shadow, w_shadow_nxt;
  logic [1:0]        r_digit, w_digit_nxt;
  logic              r_pending, w_pending_nxt;
  logic              w_frame_nxt;
  logic              w_frame_end;
  logic              w_guard_done, w_slot_end;
  logic              w_blank_nxt;
  logic [CODE_W-1:0] w_code_nxt;
  logic [3:0]        r_anode;
  logic [CODE_W-1:0] r_code_out;
  logic              r_frame_start;

  seg_slot_timer #(
    .TICK_DIV     (TICK_DIV),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (r_state == IDLE),
    .o_guard_done (w_guard_done),
    .o_slot_end   (w_slot_end)
  );

  assign w_frame_end = (r_state == DRIVE) && w_slot_end && (r_digit == 2'd3);

  always_comb begin
    w_state_nxt   = r_state;
    w_digit_nxt   = r_digit;
    w_active_nxt  = r_active;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    w_frame_nxt   = 1'b0;
    case (r_state)
      IDLE: if (load) begin
        w_state_nxt  = GUARD;
        w_digit_nxt  = 2'd0;
        w_active_nxt = code_in;
        w_frame_nxt  = 1'b1;
      end
      GUARD: if (w_guard_done) w_state_nxt = DRIVE;
      DRIVE: if (w_slot_end) begin
        w_state_nxt = GUARD;
        w_digit_nxt = r_digit + 2'd1;
        w_frame_nxt = (r_digit == 2'd3);
      end
      default: w_state_nxt = IDLE;
    endcase
    // A load on the frame edge itself goes straight to the display.
    if (w_frame_end) begin
      if (load) w_active_nxt = code_in;
      else if (r_pending) w_active_nxt = r_shadow;
      w_pending_nxt = 1'b0;
    end else if ((r_state != IDLE) && load) begin
      w_shadow_nxt  = code_in;
      w_pending_nxt = 1'b1;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] r_blink_cnt, w_blink_cnt_nxt;
  logic          r_phase_off, w_phase_off_nxt;

  // Phase flips on the first frame after each run of BLINK_FRAMES frames.
  always_comb begin
    w_blink_cnt_nxt = r_blink_cnt;
    w_phase_off_nxt = r_phase_off;
    if (w_frame_nxt) begin
      if (r_blink_cnt == BW'(BLINK_FRAMES)) begin
        w_blink_cnt_nxt = BW'(1);
        w_phase_off_nxt = ~r_phase_off;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_phase_off <= 1'b0;
    end else begin
      r_blink_cnt <= w_blink_cnt_nxt;
      r_phase_off <= w_phase_off_nxt;
    end
  end

  assign w_blank_nxt = w_phase_off_nxt & blink_mask[w_digit_nxt];
`else
  assign w_blank_nxt = 1'b0;
`endif

  always_comb begin
    w_code_nxt = w_active_nxt[w_digit_nxt*CODE_W +: CODE_W];
    if ((w_state_nxt == IDLE) || w_blank_nxt) w_code_nxt = CODE_BLANK;
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_digit       <= 2'd0;
      r_active      <= {NUM_DIGITS{CODE_BLANK}};
      r_shadow      <= {NUM_DIGITS{CODE_BLANK}};
      r_pending     <= 1'b0;
      r_anode       <= 4'b1111;
      r_code_out    <= CODE_BLANK;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_digit       <= w_digit_nxt;
      r_active      <= w_active_nxt;
      r_shadow      <= w_shadow_nxt;
      r_pending     <= w_pending_nxt;
      r_anode       <= (w_state_nxt == DRIVE) ? anode_sel_n(w_digit_nxt) : 4'b1111;
      r_code_out    <= w_code_nxt;
      r_frame_start <= w_frame_nxt;
    end
  end

  assign anode       = r_anode;
  assign code_out    = r_code_out;
  assign digit_sel   = r_digit;
  assign frame_start = r_frame_start;
  assign pending     = r_pending;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with TICK_DIV=8, GUARD_CYCLES=2.
module tb_seg_scan_ctrl;
  logic        clk;
  logic        rst;
  logic        load;
  logic [19:0] code_in;
  logic [3:0]  anode;
  logic [4:0]  code_out;
  logic [1:0]  digit_sel;
  logic        frame_start;
  logic        pending;
`ifdef SEG_BLINK_EN
  logic [3:0]  blink_mask;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int c;
  logic [3:0]  an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [19:0] v0 = {5'd4, 5'd3, 5'd2, 5'd1};

  seg_scan_ctrl #(
    .TICK_DIV     (8),
    .GUARD_CYCLES (2)
`ifdef SEG_BLINK_EN
    ,
    .BLINK_FRAMES (2)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .code_in     (code_in),
`ifdef SEG_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .anode       (anode),
    .code_out    (code_out),
    .digit_sel   (digit_sel),
    .frame_start (frame_start),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    c++;
  endtask

  // Reset, then load v in IDLE; returns at the first sample of frame 0.
  task automatic start_scan(input logic [19:0] v);
    @(negedge clk);
    rst = 1'b1;
    load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    load = 1'b1;
    code_in = v;
    @(negedge clk);
    load = 1'b0;
    c = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++;
      if (anode !== 4'b1111 || code_out !== 5'd18 || pending !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle i=%0d: got anode=%b code=%0d pend=%b required 1111/18/0",
                 i, anode, code_out, pending);
      end
    end
  endtask

  task automatic test_scan();
    int slot, pos;
    logic [3:0] exp_an;
    start_scan(v0);
    while (c <= 32) begin
      slot = (c / 8) % 4;
      pos = c % 8;
      exp_an = (pos < 2) ? 4'b1111 : an_tab[slot];
      n_cmp++;
      if (anode !== exp_an) begin
        n_err++;
        $display("FAIL scan_anode c=%0d: got %b required %b", c, anode, exp_an);
      end
      n_cmp++;
      if (code_out !== v0[slot*5 +: 5] || digit_sel !== 2'(slot)) begin
        n_err++;
        $display("FAIL scan_code c=%0d: got code=%0d sel=%0d required %0d/%0d",
                 c, code_out, digit_sel, v0[slot*5 +: 5], slot);
      end
      n_cmp++;
      if (frame_start !== (c % 32 == 0)) begin
        n_err++;
        $display("FAIL scan_frame_start c=%0d: got %b required %b", c, frame_start, (c % 32 == 0));
      end
      step();
    end
  endtask

  task automatic test_shadow();
    logic [19:0] v1;
    logic [4:0]  exp_code;
    int slot;
    v1 = {5'd0, 5'd0, 5'd0, 5'd7};
    start_scan(v0);
    while (c < 10) step();
    load = 1'b1;
    code_in = v1;
    step();
    load = 1'b0;
    while (c <= 40) begin
      slot = (c / 8) % 4;
      exp_code = (c < 32) ? v0[slot*5 +: 5] : v1[slot*5 +: 5];
      n_cmp++;
      if (code_out !== exp_code) begin
        n_err++;
        $display("FAIL shadow_code c=%0d: got %0d required %0d", c, code_out, exp_code);
      end
      n_cmp++;
      if (pending !== (c < 32)) begin
        n_err++;
        $display("FAIL shadow_pending c=%0d: got %b required %b", c, pending, (c < 32));
      end
      step();
    end
  endtask

  task automatic test_two_loads();
    logic [19:0] va, vb;
    logic [4:0]  exp_code;
    int slot;
    va = {5'd24, 5'd23, 5'd22, 5'd21};
    vb = {5'd14, 5'd13, 5'd12, 5'd11};
    start_scan(v0);
    while (c < 64) begin
      slot = (c / 8) % 4;
      exp_code = (c < 32) ? v0[slot*5 +: 5] : vb[slot*5 +: 5];
      n_cmp++;
      if (code_out !== exp_code || (code_out >= 5'd21 && code_out <= 5'd24)) begin
        n_err++;
        $display("FAIL two_loads_code c=%0d: got %0d required %0d", c, code_out, exp_code);
      end
      n_cmp++;
      if (pending !== (c >= 6 && c < 32)) begin
        n_err++;
        $display("FAIL two_loads_pending c=%0d: got %b required %b", c, pending, (c >= 6 && c < 32));
      end
      load = (c == 5) || (c == 20);
      code_in = (c == 5) ? va : vb;
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_boundary_load();
    logic [19:0] va, vc;
    logic [4:0]  exp_code;
    int slot;
    va = {5'd24, 5'd23, 5'd22, 5'd21};
    vc = {5'd15, 5'd16, 5'd17, 5'd19};
    start_scan(v0);
    while (c < 64) begin
      slot = (c / 8) % 4;
      exp_code = (c < 32) ? v0[slot*5 +: 5] : vc[slot*5 +: 5];
      n_cmp++;
      if (code_out !== exp_code) begin
        n_err++;
        $display("FAIL boundary_code c=%0d: got %0d required %0d", c, code_out, exp_code);
      end
      n_cmp++;
      if (pending !== (c >= 11 && c < 32)) begin
        n_err++;
        $display("FAIL boundary_pending c=%0d: got %b required %b", c, pending, (c >= 11 && c < 32));
      end
      load = (c == 10) || (c == 31);
      code_in = (c == 10) ? va : vc;
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [19:0] v2;
    v2 = {5'd1, 5'd2, 5'd3, 5'd9};
    start_scan(v0);
    while (c < 4) begin
      load = (c == 2);
      code_in = v2;
      step();
    end
    load = 1'b0;
    n_cmp++;
    if (anode !== 4'b1110 || pending !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: got anode=%b pend=%b required 1110/1", anode, pending);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (anode !== 4'b1111 || code_out !== 5'd18 || pending !== 1'b0 ||
        digit_sel !== 2'd0 || frame_start !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got anode=%b code=%0d pend=%b sel=%0d fs=%b required 1111/18/0/0/0",
               anode, code_out, pending, digit_sel, frame_start);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (anode !== 4'b1111 || code_out !== 5'd18) begin
        n_err++;
        $display("FAIL post_reset_idle i=%0d: got anode=%b code=%0d required 1111/18", i, anode, code_out);
      end
    end
    load = 1'b1;
    code_in = v2;
    @(negedge clk);
    load = 1'b0;
    n_cmp++;
    if (code_out !== 5'd9 || frame_start !== 1'b1 || pending !== 1'b0) begin
      n_err++;
      $display("FAIL reload_after_reset: got code=%0d fs=%b pend=%b required 9/1/0", code_out, frame_start, pending);
    end
  endtask

`ifdef SEG_BLINK_EN
  task automatic test_blink();
    logic [4:0] exp_code;
    int slot, frame;
    blink_mask = 4'b0001;
    start_scan(v0);
    while (c < 6 * 32) begin
      slot = (c / 8) % 4;
      frame = c / 32;
      exp_code = (slot == 0 && (frame / 2) % 2 == 1) ? 5'd18 : v0[slot*5 +: 5];
      n_cmp++;
      if (code_out !== exp_code) begin
        n_err++;
        $display("FAIL blink_code c=%0d: got %0d required %0d", c, code_out, exp_code);
      end
      n_cmp++;
      if (anode !== ((c % 8 < 2) ? 4'b1111 : an_tab[slot])) begin
        n_err++;
        $display("FAIL blink_anode c=%0d: got %b", c, anode);
      end
      step();
    end
    blink_mask = 4'b0000;
  endtask
`endif

  initial begin
    rst = 1'b1;
    load = 1'b0;
    code_in = '0;
`ifdef SEG_BLINK_EN
    blink_mask = 4'b0000;
`endif
    test_reset();
    test_scan();
    test_shadow();
    test_two_loads();
    test_boundary_load();
`ifdef SEG_BLINK_EN
    test_blink();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
